// File: rtl/snpu_trng_harvester.sv
// Clocked, stallable, health-checked random word source built on external metastable latches.
// Optional von Neumann debiasing is built when SNPU_VN_DEBIAS_EN is defined.
module snpu_trng_harvester #(
  parameter int CHANNELS   = 16,
  parameter int WORD_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int REP_LIMIT  = 31
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [CHANNELS-1:0] i_ent_in,
  output logic                o_src_gate,
  output logic [WORD_W-1:0]   o_rnd_data,
  output logic                o_rnd_valid,
  input  logic                i_rnd_ready,
  input  logic                i_clr_err,
  output logic                o_health_err
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXCITE, SETTLE, SAMPLE} state_t;

  state_t              r_state;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [WORD_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [7:0]          r_rep_cnt;
  logic                r_last_bit;

  logic       w_raw_bit;
  logic       w_raw_valid;
  logic       w_full;
  logic       w_load;
  logic       w_rep_err;
  logic       w_accept;
  logic       w_acc_bit;
  logic [7:0] w_rep_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_ent_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw_bit   = ^r_sync2;
  assign w_raw_valid = (r_state == SAMPLE) && i_en;
  assign w_full      = (r_bit_cnt == CNT_W'(WORD_W));
  assign w_load      = w_full && (!o_rnd_valid || i_rnd_ready);

  always_comb begin
    w_rep_next = 8'd1;
    if ((r_rep_cnt != 8'd0) && (w_raw_bit == r_last_bit)) begin
      w_rep_next = r_rep_cnt + 8'd1;
    end
  end

  assign w_rep_err = w_raw_valid && (w_rep_next == 8'(REP_LIMIT));

`ifdef SNPU_VN_DEBIAS_EN
  logic r_pair_have;
  logic r_pair_first;

  // A pair is accepted only when its two raw bits differ; the first bit is the output.
  assign w_accept  = w_raw_valid && r_pair_have && (r_pair_first != w_raw_bit);
  assign w_acc_bit = r_pair_first;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en || w_rep_err) begin
      r_pair_have  <= 1'b0;
      r_pair_first <= 1'b0;
    end else if (w_raw_valid) begin
      r_pair_have  <= !r_pair_have;
      r_pair_first <= w_raw_bit;
    end
  end
`else
  assign w_accept  = w_raw_valid;
  assign w_acc_bit = w_raw_bit;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rep_cnt  <= 8'd0;
      r_last_bit <= 1'b0;
    end else if (w_raw_valid) begin
      r_last_bit <= w_raw_bit;
      r_rep_cnt  <= (i_clr_err && !w_rep_err) ? 8'd0 : w_rep_next;
    end else if (i_clr_err || !i_en) begin
      r_rep_cnt <= 8'd0;
    end
  end

  // A health failure overrides everything, including a simultaneous clear request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      o_rnd_data   <= '0;
      o_rnd_valid  <= 1'b0;
      o_health_err <= 1'b0;
    end else if (w_rep_err) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      o_rnd_valid  <= 1'b0;
      o_health_err <= 1'b1;
    end else begin
      if (i_clr_err) begin
        o_health_err <= 1'b0;
      end
      if (w_load) begin
        o_rnd_data  <= r_shift;
        o_rnd_valid <= 1'b1;
      end else if (o_rnd_valid && i_rnd_ready) begin
        o_rnd_valid <= 1'b0;
      end
      if (!i_en) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_load) begin
        r_bit_cnt <= '0;
      end else if (w_accept) begin
        r_shift   <= (r_shift << 1) | WORD_W'(w_acc_bit);
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // IDLE may start the next sample in the same cycle the full word is handed off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      o_src_gate   <= 1'b1;
    end else if (!i_en) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      o_src_gate   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!o_health_err && (!w_full || w_load)) begin
            r_state    <= EXCITE;
            o_src_gate <= 1'b0;
          end
        end
        EXCITE: begin
          r_state      <= SETTLE;
          r_settle_cnt <= SET_W'(SETTLE_CYC - 1);
          o_src_gate   <= 1'b1;
        end
        SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state <= SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - SET_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snpu_trng_harvester.sv
// Self-checking bench for snpu_trng_harvester: reset, fold path, table vectors, random words
// against a bit-level model, backpressure, health test and enable drop.
module tb_snpu_trng_harvester;
  localparam int CH = 4;
  localparam int WW = 8;
  localparam int SC = 4;
  localparam int RL = 8;
  localparam int PERIOD = SC + 3;
`ifdef SNPU_VN_DEBIAS_EN
  localparam int RAW_PER_BIT = 2;
`else
  localparam int RAW_PER_BIT = 1;
`endif
  localparam int LATENCY = WW * RAW_PER_BIT * PERIOD + 1;

  typedef struct {
    logic [7:0] foldBits;
    logic [7:0] expWord;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          en;
  logic          rndReady;
  logic          clrErr;
  logic [CH-1:0] entIn = '0;
  logic          srcGate;
  logic          rndValid;
  logic          healthErr;
  logic [WW-1:0] rndData;

  int         vecCount = 0;
  int         failCount = 0;
  bit         rawQ[$];
  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  bit         lastDriven = 1'b0;
  bit         checkStable = 1'b0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData = '0;

  always #5 clk = ~clk;

  snpu_trng_harvester #(
    .CHANNELS(CH), .WORD_W(WW), .SETTLE_CYC(SC), .REP_LIMIT(RL)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_ent_in(entIn),
    .o_src_gate(srcGate), .o_rnd_data(rndData), .o_rnd_valid(rndValid),
    .i_rnd_ready(rndReady), .i_clr_err(clrErr), .o_health_err(healthErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Entropy source: during EXCITE, drive a random channel pattern whose parity is the next raw bit.
  always @(negedge clk) begin : srcBlk
    bit b;
    logic [CH-1:0] pat;
    if (rstN === 1'b1 && srcGate === 1'b0) begin
      if (rawQ.size() > 0) b = rawQ.pop_front();
      else b = ~lastDriven;
      lastDriven = b;
      pat = CH'($urandom_range(0, 15));
      if ((^pat) != b) pat[0] = ~pat[0];
      entIn = pat;
    end
  end

  // Output monitor: collects transferred words and checks hold behaviour while stalled.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (checkStable && prevValid && !prevReady) begin
        checkOutput("validHeld", 32'(rndValid), 32'h1);
        checkOutput("dataStable", 32'(rndData), 32'(prevData));
      end
      if (rndValid && rndReady) gotQ.push_back(rndData);
      prevValid = rndValid;
      prevReady = rndReady;
      prevData  = rndData;
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    en = 1'b0; rndReady = 1'b0; clrErr = 1'b0; rstN = 1'b0;
    tick(2);
    rstN = 1'b1;
    rawQ.delete(); gotQ.delete(); lastDriven = 1'b0; checkStable = 1'b0;
    tick(1);
  endtask

  // Queue the raw bits that make the given word emerge, first bit in the MSB.
  task automatic applyStimulus(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      rawQ.push_back(w[i]);
`ifdef SNPU_VN_DEBIAS_EN
      rawQ.push_back(~w[i]);
`endif
    end
  endtask

  task automatic waitWords(input int k, input int budget, input bit randReady, input string name);
    int n = 0;
    while (gotQ.size() < k && n < budget) begin
      if (randReady) rndReady = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    if (gotQ.size() < k) checkOutput(name, 32'(gotQ.size()), 32'(k));
  endtask

  // Reference model: raw bit list -> accepted bits -> words, first accepted bit in the MSB.
  task automatic buildExpected(input bit raw[$]);
    bit acc[$];
`ifdef SNPU_VN_DEBIAS_EN
    bit havePair = 1'b0;
    bit first = 1'b0;
`endif
    expQ.delete();
    foreach (raw[i]) begin
`ifdef SNPU_VN_DEBIAS_EN
      if (!havePair) begin
        first = raw[i];
        havePair = 1'b1;
      end else begin
        havePair = 1'b0;
        if (first != raw[i]) acc.push_back(first);
      end
`else
      acc.push_back(raw[i]);
`endif
    end
    for (int w = 0; w + 8 <= acc.size(); w += 8) begin
      int val;
      val = 0;
      for (int j = 0; j < 8; j++) val = val * 2 + int'(acc[w + j]);
      expQ.push_back(8'(val));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t table1[5];
    bit genRaw[$];
    bit lastRaw;
    bit b;
    int run;
    int pulses;
    int n;

    table1[0] = '{8'b1010_0101, 8'hA5};
    table1[1] = '{8'b1100_1100, 8'hCC};
    table1[2] = '{8'b0111_0001, 8'h71};
    table1[3] = '{8'b1000_1110, 8'h8E};
    table1[4] = '{8'b0011_0110, 8'h36};

    // Reset held with enable high
    rstN = 1'b0; en = 1'b1; rndReady = 1'b0; clrErr = 1'b0;
    tick(2);
    checkOutput("rstGate", 32'(srcGate), 32'h1);
    checkOutput("rstValid", 32'(rndValid), 32'h0);
    checkOutput("rstData", 32'(rndData), 32'h0);
    checkOutput("rstErr", 32'(healthErr), 32'h0);
    rstN = 1'b1;
    checkOutput("gateAtRelease", 32'(srcGate), 32'h1);
    tick(1);
    checkOutput("firstExcite", 32'(srcGate), 32'h0);

    // Fold path timing: alternating bits give 0xAA
    resetDut();
    rndReady = 1'b1;
    applyStimulus(8'b1010_1010);
    en = 1'b1;
    tick(LATENCY - 1);
    checkOutput("t2ValidEarly", 32'(rndValid), 32'h0);
    tick(1);
    checkOutput("t2ValidOnTime", 32'(rndValid), 32'h1);
    checkOutput("t2Data", 32'(rndData), 32'hAA);

    // Table vectors
    resetDut();
    rndReady = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(table1[i].foldBits);
    en = 1'b1;
    waitWords(5, 6 * LATENCY, 1'b0, "tableTimeout");
    for (int i = 0; i < 5; i++) begin
      if (i < gotQ.size()) checkOutput($sformatf("table%0d", i), 32'(gotQ[i]), 32'(table1[i].expWord));
    end

`ifdef SNPU_VN_DEBIAS_EN
    // Debias pairs: only (1,0) and (0,1) contribute
    resetDut();
    rndReady = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rawQ.push_back(1); rawQ.push_back(0); rawQ.push_back(1); rawQ.push_back(1);
      rawQ.push_back(0); rawQ.push_back(1); rawQ.push_back(0); rawQ.push_back(0);
    end
    en = 1'b1;
    waitWords(1, 40 * PERIOD, 1'b0, "debiasTimeout");
    if (gotQ.size() > 0) checkOutput("debiasWord", 32'(gotQ[0]), 32'hAA);
`endif

    // Random raw bits with random backpressure against the model
    resetDut();
    genRaw.delete();
    run = 0; lastRaw = 1'b0;
    do begin
      b = 1'($urandom_range(0, 1));
      if (run >= 6 && b == lastRaw) b = ~b;
      if (genRaw.size() == 0 || b != lastRaw) run = 1;
      else run++;
      lastRaw = b;
      genRaw.push_back(b);
      buildExpected(genRaw);
    end while (expQ.size() < 6);
    foreach (genRaw[i]) rawQ.push_back(genRaw[i]);
    checkStable = 1'b1;
    en = 1'b1;
    waitWords(6, 8000, 1'b1, "randTimeout");
    checkStable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < gotQ.size()) checkOutput($sformatf("rand%0d", i), 32'(gotQ[i]), 32'(expQ[i]));
    end

    // Backpressure: first word held, FSM stalls once the next word is complete
    resetDut();
    applyStimulus(8'h5A);
    applyStimulus(8'h3C);
    en = 1'b1;
    n = 0;
    while (!rndValid && n < 2 * LATENCY) begin
      tick(1);
      n++;
    end
    checkOutput("bpFirstValid", 32'(rndValid), 32'h1);
    checkOutput("bpFirstData", 32'(rndData), 32'h5A);
    tick(LATENCY + 20);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!srcGate) pulses++;
    end
    checkOutput("bpNoExcite", 32'(pulses), 32'h0);
    checkOutput("bpHeldValid", 32'(rndValid), 32'h1);
    checkOutput("bpHeldData", 32'(rndData), 32'h5A);
    rndReady = 1'b1;
    tick(1);
    rndReady = 1'b0;
    checkOutput("bpSecondValid", 32'(rndValid), 32'h1);
    checkOutput("bpSecondData", 32'(rndData), 32'h3C);
    n = 0;
    while (srcGate && n < 4) begin
      tick(1);
      n++;
    end
    checkOutput("bpResume", 32'(srcGate), 32'h0);

    // Health: eight identical raw bits; clear in the same cycle loses to the error
    resetDut();
    rndReady = 1'b1;
    for (int i = 0; i < RL; i++) rawQ.push_back(1'b1);
    en = 1'b1;
    tick(RL * PERIOD - 1);
    checkOutput("hlthBefore", 32'(healthErr), 32'h0);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checkOutput("hlthErrWins", 32'(healthErr), 32'h1);
    checkOutput("hlthValid", 32'(rndValid), 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!srcGate) pulses++;
    end
    checkOutput("hlthNoExcite", 32'(pulses), 32'h0);
    checkOutput("hlthSticky", 32'(healthErr), 32'h1);
    checkOutput("hlthNoWord", 32'(gotQ.size()), 32'h0);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checkOutput("hlthCleared", 32'(healthErr), 32'h0);
    n = 0;
    while (srcGate && n < 5) begin
      tick(1);
      n++;
    end
    checkOutput("hlthResume", 32'(srcGate), 32'h0);

    // Enable drop mid-word discards the partial word
    resetDut();
    rndReady = 1'b1;
    rawQ.push_back(1); rawQ.push_back(0); rawQ.push_back(0); rawQ.push_back(1); rawQ.push_back(1);
    en = 1'b1;
    tick(5 * PERIOD + 1);
    checkOutput("enExcite", 32'(srcGate), 32'h0);
    en = 1'b0;
    tick(1);
    checkOutput("enIdle", 32'(srcGate), 32'h1);
    tick(3);
    checkOutput("enStillIdle", 32'(srcGate), 32'h1);
    checkOutput("enNoValid", 32'(rndValid), 32'h0);
    rawQ.delete();
    applyStimulus(8'h96);
    en = 1'b1;
    tick(LATENCY - 1);
    checkOutput("enValidEarly", 32'(rndValid), 32'h0);
    tick(1);
    checkOutput("enValidOnTime", 32'(rndValid), 32'h1);
    checkOutput("enFreshWord", 32'(rndData), 32'h96);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end
endmodule

// File: doc/snpu_trng_harvester.md
# snpu_trng_harvester

Parametrised true-random word generator for the SNPU. It excites an array of external metastable NAND-latch entropy cells and samples them through synchronisers, then XOR-folds the samples into one bit. Optional von Neumann debiasing follows, and a repetition-count health test guards the output. Finished words go out over a valid/ready port. It replaces free-running, unsynchronised latch outputs with a clocked, stallable, health-checked random source.

## Interface
- `CHANNELS`, 16: number of entropy cells, range 1..64.
- `WORD_W`, 8: output word width, range 1..32.
- `SETTLE_CYC`, 4: settle and synchroniser cycles per sample, minimum 3.
- `REP_LIMIT`, 31: count of consecutive identical raw bits that flags a health error, range 2..255.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: run enable.
- `ent_in` in `CHANNELS`: asynchronous latch outputs.
- `src_gate` out 1: shared latch excite. 0 forces the latches to Q=1; the 0→1 edge releases the latch race.
- `rnd_data` out `WORD_W`: random word.
- `rnd_valid` out 1: `rnd_data` is valid.
- `rnd_ready` in 1: consumer accepts the word.
- `clr_err` in 1: clears `health_err`.
- `health_err` out 1: sticky health failure.

## Operation
- `ent_in` goes through a 2-flop synchroniser per channel every cycle, independent of FSM state.
- FSM states:
  - IDLE, `src_gate`=1.
    - Moves to EXCITE when `en`=1, `health_err`=0 and the shift register is not full.
  - EXCITE, `src_gate`=0, 1 cycle. Always moves to SETTLE.
  - SETTLE, `src_gate`=1, `SETTLE_CYC` cycles, counted by a down-counter. Moves to SAMPLE.
  - SAMPLE, `src_gate`=1, 1 cycle. Captures the XOR of all synchronised channels as the raw bit, then returns to IDLE.
- Raw bit path:
  - Health test sees every raw bit.
  - With debias (see Configuration), the debias stage sees every raw bit.
  - Without debias, each raw bit is accepted directly.
- Accepted bits shift into the LSB of a `WORD_W` shift register, shifting left, so the first bit ends up in the MSB. A bit counter tracks the fill.
- Word transfer:
  - When the counter equals `WORD_W` and `rnd_valid`=0 (or `rnd_valid`=1 and `rnd_ready`=1 in the same cycle), the word loads into `rnd_data`.
  - `rnd_valid` goes 1 on the next edge and the counter clears.
  - When full and blocked, the FSM holds in IDLE; this is the stall.
- Handshake:
  - Transfer occurs on `rnd_valid`&`rnd_ready`.
  - `rnd_valid` never drops without a transfer, except on reset or health error.
  - `rnd_data` is stable while `rnd_valid`=1.
- Health test:
  - A repeat counter tracks the raw bit. An equal bit increments it; a different bit sets it to 1; the first bit after clear sets it to 1.
  - When the counter reaches `REP_LIMIT`, `health_err` goes 1 and the following are cleared: `rnd_valid`, the shift register, the bit counter and the debias pair state.
  - `health_err` holds until `clr_err`=1 or reset. `clr_err` also zeroes the repeat counter.
  - If an error and `clr_err` occur in the same cycle, the error wins.
- `en`=0:
  - The FSM returns to IDLE on the next edge, from any state, and `src_gate` returns to 1.
  - The partial word, bit counter, debias pair state and repeat counter clear.
  - A pending `rnd_valid` word is kept until it is consumed.

## Timing
- Reset values: `src_gate`=1, `rnd_valid`=0, `rnd_data`=0, `health_err`=0; FSM in IDLE, all counters 0.
- Sample period is `SETTLE_CYC`+3 cycles (IDLE, EXCITE, SETTLE, SAMPLE); 7 at the defaults.
- The raw bit is registered at the end of SAMPLE.
- Without debias, the first word arrives 1 cycle after the `WORD_W`th SAMPLE, measured from the cycle `en` rises.
- `health_err` rises 1 cycle after the offending SAMPLE.
- Throughput is one word per `WORD_W`×(`SETTLE_CYC`+3) cycles when not debiased and `rnd_ready` is held at 1.

## Configuration
- Macro `SNPU_VN_DEBIAS_EN`.
- When defined: raw bits are paired (first, second).
  - (1,0) → accept 1.
  - (0,1) → accept 0.
  - (0,0) and (1,1) → discard.
  - Pair state resets after each second bit.
- When undefined: no pair logic is built and every raw bit is accepted.

## Test plan
All scenarios use `CHANNELS`=4, `WORD_W`=8, `SETTLE_CYC`=4, `REP_LIMIT`=8, with `ent_in` driven by the bench and synchronous to sampling.
1. Reset: hold `rst_n`=0 for 2 edges with `en`=1 → `src_gate`=1, `rnd_valid`=0, `rnd_data`=0x00, `health_err`=0; the `src_gate`=0 EXCITE pulse starts no earlier than 1 cycle after `rst_n` rises.
2. Fold path, no debias: drive folded bits 1,0,1,0,1,0,1,0, for example `ent_in`=4'b0001 then 4'b0011 alternately → `rnd_data`=0xAA, `rnd_valid`=1 exactly 8×7+1 cycles after `en` rises.
3. Debias (`SNPU_VN_DEBIAS_EN`): raw bits 1,0 / 1,1 / 0,1 / 0,0 repeated → only 1,0 are accepted per 8 raw bits; after 32 raw bits the word is 0xAA.
4. Backpressure: `rnd_ready`=0 → the first word is held stable, the shift register fills, `src_gate` stays 1 with no EXCITE pulses; raising `rnd_ready` for 1 cycle → the second word loads on the next edge.
5. Health: folded bit constant 1 for 8 samples → `health_err`=1 after the 8th SAMPLE, `rnd_valid`=0, no EXCITE pulses; pulse `clr_err` → `health_err`=0 and sampling resumes.
6. `en` drop mid-word after 5 bits → the FSM returns to IDLE on the next edge; after `en` returns, the next word contains only the 8 new bits.
